// File: rtl/ch0re_pkg.sv
// Shared types and constants for the unified code/data memory arbiter.
package ch0re_pkg;

  typedef enum logic [1:0] {
    RESP_NONE   = 2'd0,
    RESP_IFETCH = 2'd1,
    RESP_DLOAD  = 2'd2
  } resp_owner_e;

  localparam int unsigned DWORD_OFFSET_BITS = 3;
  localparam int unsigned IFETCH_HALF_BIT   = 2;

endpackage

// File: rtl/ch0re_starve_ctr.sv
// Saturating counter of consecutive refused fetch cycles; at_limit forces a fetch grant.
module ch0re_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == CW'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ch0re_mem_arbiter.sv
// Arbitrates a single-port 64-bit memory between instruction fetch and the load/store path.
module ch0re_mem_arbiter
  import ch0re_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_ireq_valid,
  output logic                      o_ireq_ready,
  input  logic [63:0]               i_ireq_addr,
  output logic                      o_iresp_valid,
  output logic [31:0]               o_iresp_data,
  output logic                      o_iresp_misaligned,
  input  logic                      i_dreq_valid,
  output logic                      o_dreq_ready,
  input  logic [63:0]               i_dreq_addr,
  input  logic [7:0]                i_dreq_wen,
  input  logic [63:0]               i_dreq_wdata,
  output logic                      o_dresp_valid,
  output logic [63:0]               o_dresp_data,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]                o_mem_wen,
  output logic [63:0]               o_mem_wdata,
  input  logic [63:0]               i_mem_rdata
);

  localparam int unsigned ADDR_LSB = DWORD_OFFSET_BITS;
  localparam int unsigned ADDR_MSB = MEM_ADDR_WIDTH + DWORD_OFFSET_BITS - 1;

  logic                      igrant, dgrant, starve_hit;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  resp_owner_e               owner_q, owner_d;
  logic                      ihalf_q, ihalf_d;
  logic                      imis_q, imis_d;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^{i_ireq_addr[63:ADDR_MSB+1], i_dreq_addr[63:ADDR_MSB+1],
                              i_dreq_addr[ADDR_LSB-1:0]};

  ch0re_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (i_ireq_valid && !igrant),
    .clr      (!i_ireq_valid || igrant),
    .at_limit (starve_hit)
  );

  // Data has priority unless fetch has been refused STARVE_LIMIT cycles in a row.
  always_comb begin
    igrant = 1'b0;
    dgrant = 1'b0;
    if (!rst) begin
      if (i_ireq_valid && (!i_dreq_valid || starve_hit)) begin
        igrant = 1'b1;
      end else if (i_dreq_valid) begin
        dgrant = 1'b1;
      end
    end
  end

  assign o_ireq_ready = igrant;
  assign o_dreq_ready = dgrant;

  // Memory address follows the grant and holds its last value when idle.
  always_comb begin
    mem_addr_d = mem_addr_q;
    if (igrant) begin
      mem_addr_d = i_ireq_addr[ADDR_MSB:ADDR_LSB];
    end else if (dgrant) begin
      mem_addr_d = i_dreq_addr[ADDR_MSB:ADDR_LSB];
    end
  end

  assign o_mem_addr  = mem_addr_d;
  assign o_mem_wen   = dgrant ? i_dreq_wen : 8'h00;
  assign o_mem_wdata = rst ? 64'h0 : i_dreq_wdata;

  // Response owner: who gets the memory read data on the next cycle.
  always_comb begin
    owner_d = RESP_NONE;
    ihalf_d = ihalf_q;
    imis_d  = imis_q;
    if (igrant) begin
      owner_d = RESP_IFETCH;
      ihalf_d = i_ireq_addr[IFETCH_HALF_BIT];
      imis_d  = |i_ireq_addr[1:0];
    end else if (dgrant && (i_dreq_wen == 8'h00)) begin
      owner_d = RESP_DLOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= RESP_NONE;
      ihalf_q    <= 1'b0;
      imis_q     <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      owner_q    <= owner_d;
      ihalf_q    <= ihalf_d;
      imis_q     <= imis_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_comb begin
    o_iresp_valid      = 1'b0;
    o_iresp_data       = 32'h0;
    o_iresp_misaligned = 1'b0;
    o_dresp_valid      = 1'b0;
    o_dresp_data       = 64'h0;
    case (owner_q)
      RESP_IFETCH: begin
        o_iresp_valid      = 1'b1;
        o_iresp_data       = ihalf_q ? i_mem_rdata[63:32] : i_mem_rdata[31:0];
        o_iresp_misaligned = imis_q;
      end
      RESP_DLOAD: begin
        o_dresp_valid = 1'b1;
        o_dresp_data  = i_mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ch0re_mem_arbiter.md
Name: ch0re_mem_arbiter

Overview:
- Arbitrates one synchronous single-port 64-bit memory between two requesters: instruction fetch (read-only, 32-bit) and the load/store path (64-bit read/write with byte enables).
- Lets the core run from a unified code/data RAM instead of split imem/dmem.
- Sits between the fetch/memory stages and the memory macro.
- Fixed priority to data accesses, with a starvation guard for fetch.

Parameters:
- MEM_ADDR_WIDTH, 10, word-address width of the shared memory (1024 x 64-bit = 8 KiB).
- STARVE_LIMIT, 4, consecutive cycles a fetch may be refused while valid before it is forced to win.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- i_ireq_valid  in  1  fetch request valid.
- o_ireq_ready  out  1  fetch request accepted this cycle.
- i_ireq_addr  in  64  fetch byte address.
- o_iresp_valid  out  1  fetch data valid.
- o_iresp_data  out  32  fetched instruction.
- o_iresp_misaligned  out  1  accepted fetch had addr[1:0] != 0; qualifies o_iresp_valid.
- i_dreq_valid  in  1  data request valid.
- o_dreq_ready  out  1  data request accepted this cycle.
- i_dreq_addr  in  64  data byte address; bits [2:0] are ignored by the arbiter.
- i_dreq_wen  in  8  byte write enables; 0 means read.
- i_dreq_wdata  in  64  store data, already lane-aligned.
- o_dresp_valid  out  1  load data valid (reads only).
- o_dresp_data  out  64  raw 64-bit memory word.
- o_mem_addr  out  MEM_ADDR_WIDTH  memory word address.
- o_mem_wen  out  8  memory byte write enables.
- o_mem_wdata  out  64  memory write data.
- i_mem_rdata  in  64  memory read data, valid 1 cycle after the address.

Behaviour:
- Handshake:
  - A request transfers on valid & ready in the same cycle.
  - Ready is combinational from valid, the starvation state and nothing else.
  - Requesters hold address and data stable until accepted.
- Grant, one per cycle:
  - If only one requester is valid, it is granted.
  - If both are valid, data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - Exactly one of o_ireq_ready / o_dreq_ready is high when any valid is high.
  - When no requester is valid, both readies are 0.
- Memory drive on the grant cycle:
  - o_mem_addr = granted addr[MEM_ADDR_WIDTH+2:3].
  - o_mem_wen = i_dreq_wen only for a data grant, else 0.
  - o_mem_wdata = i_dreq_wdata.
  - With no grant: o_mem_wen = 0 and the address holds its last value.
- Response tracking uses a registered owner state resp_owner in {NONE, IFETCH, DLOAD}, plus ihalf (addr[2]) and imis.
  - Fetch grant -> IFETCH.
  - Data read grant -> DLOAD.
  - Data write or no grant -> NONE.
- Response cycle (one cycle after grant):
  - IFETCH: o_iresp_valid = 1; o_iresp_data = ihalf ? i_mem_rdata[63:32] : i_mem_rdata[31:0]; o_iresp_misaligned = imis.
  - DLOAD: o_dresp_valid = 1; o_dresp_data = i_mem_rdata.
  - Response valids are decoded from resp_owner; data is a mux on i_mem_rdata.
- Throughput: a new grant may occur in the same cycle as a response, so back-to-back accesses run at 1 per cycle with 1-cycle latency.
- Writes produce no response. A read granted in the cycle after a write to the same word returns the new data (memory is write-first across cycles).
- Starvation counter starve_cnt (width $clog2(STARVE_LIMIT+1)):
  - Increments when i_ireq_valid & !o_ireq_ready.
  - Clears to 0 on a fetch grant or when i_ireq_valid = 0.
  - Saturates at STARVE_LIMIT.
- Misaligned fetch: still performed and returned, with o_iresp_misaligned = 1. Exception handling is left to the pipeline.
- Reset, asynchronous: resp_owner = NONE, starve_cnt = 0, ihalf = 0, imis = 0.
  - All outputs read 0: valids 0, readies 0, o_mem_wen 0, o_mem_addr 0, data 0.
  - Reset during an outstanding read drops that response; no valid pulse appears after release.
- Invariant: o_iresp_valid & o_dresp_valid is never 1.

Decomposition:
- ch0re_pkg holds resp_owner_e {RESP_NONE, RESP_IFETCH, RESP_DLOAD} and a DWORD_OFFSET_BITS = 3 constant.
- One natural sub-module, ch0re_starve_ctr: a parameterized saturating counter with inc/clr/at_limit. Instantiate it once.
- Grant logic and response mux stay in the top module.

Test Plan:
- Fetch only: addr 0x0, then 0x4, with the memory word holding 0x11112222_33334444 -> o_iresp_data 0x33334444, then 0x11112222, each 1 cycle after its grant; ireq_ready stays 1 throughout.
- Store then load: write wen 0xFF, data 0xDEADBEEF_CAFEF00D to addr 0x40 -> no dresp. Load 0x40 next cycle -> o_dresp_valid with 0xDEADBEEF_CAFEF00D.
- Contention with STARVE_LIMIT = 4: both valid continuously -> dreq granted in cycles 0-3, ireq granted in cycle 4, starve_cnt returns to 0, then data wins again.
- Misaligned fetch addr 0x6 -> o_iresp_valid = 1 and o_iresp_misaligned = 1, data taken from the upper half.
- Reset asserted in the cycle after a load grant -> o_dresp_valid never pulses, all outputs 0 asynchronously; after release a fetch of 0x0 completes normally.
- Random mix of 2000 requests against a memory model -> responses in order, never two valids in one cycle, fetch never refused more than STARVE_LIMIT consecutive cycles.
